key_sched_ctrl: RTL and testbench

Sequencer and storage for the AES-128 key schedule. Accepts a 128-bit cipher key through a valid/ready handshake and drives one `GENERATE_KEY` instance for ten rounds, one round per cycle. It stores all eleven round keys (round 0 = cipher key) in an internal register file. The encryption round controller then reads those keys by index, so key expansion runs once per key rather than once per block.

---
 rtl/key_sched_ctrl.sv | 179 +++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// AES-128 key expansion: one round of the key schedule (next round key from current key + round index).
// Latency: purely combinational, settles within the caller's cycle.
// Backpressure: none, output follows inputs every cycle.
module generate_key (
  input  logic [3:0]   i_round_key,
  input  logic [127:0] i_in_key,
  output logic [127:0] o_out_key
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i > 0) r = gf_mul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  w_rcon;
  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  // Round constant for rounds 0..9; indices beyond the AES-128 range yield zero
  always_comb begin
    w_rcon = 8'h00;
    case (i_round_key)
      4'd0:    w_rcon = 8'h01;
      4'd1:    w_rcon = 8'h02;
      4'd2:    w_rcon = 8'h04;
      4'd3:    w_rcon = 8'h08;
      4'd4:    w_rcon = 8'h10;
      4'd5:    w_rcon = 8'h20;
      4'd6:    w_rcon = 8'h40;
      4'd7:    w_rcon = 8'h80;
      4'd8:    w_rcon = 8'h1b;
      4'd9:    w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_w0 = i_in_key[127:96];
  assign w_w1 = i_in_key[95:64];
  assign w_w2 = i_in_key[63:32];
  assign w_w3 = i_in_key[31:0];

  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_temp = w_sub ^ {w_rcon, 24'h000000};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  assign o_out_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// Sequences one generate_key over ten rounds and stores all eleven AES-128 round keys for indexed reads.
// Latency: expansion 10 cycles after key accept; round-key read 1 cycle (registered).
// Backpressure: key_ready low during expansion; key_valid then ignored, nothing queued.
module key_sched_ctrl (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_valid,
  input  logic [127:0] i_key_in,
  output logic         o_key_ready,
  output logic         o_busy,
  output logic         o_keys_valid,
  input  logic [3:0]   i_rk_addr,
  output logic [127:0] o_rk_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_cur;
  logic [127:0] r_rk [0:10];
  logic         r_key_ready;
  logic         r_busy;
  logic         r_keys_valid;
  logic [127:0] r_rk_data;

  logic [127:0] w_next_key;
  logic [3:0]   w_wr_idx;

  assign w_wr_idx = r_cnt + 4'd1;

  generate_key u_generate_key (
    .i_round_key (r_cnt),
    .i_in_key    (r_cur),
    .o_out_key   (w_next_key)
  );

  // Control FSM: accepts a key in IDLE/DONE, then writes one round key per cycle into the register file
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_cur        <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_key_valid) begin
            r_rk[0]      <= i_key_in;
            r_cur        <= i_key_in;
            r_cnt        <= 4'd0;
            r_state      <= S_EXPAND;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        S_EXPAND: begin
          r_rk[w_wr_idx] <= w_next_key;
          r_cur          <= w_next_key;
          if (r_cnt == 4'd9) begin
            r_cnt        <= 4'd0;
            r_state      <= S_DONE;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
          end else begin
            r_cnt <= w_wr_idx;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= 4'd0;
          r_key_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; same-edge writes are not forwarded, indices past 10 read as zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rk_data <= '0;
    end else if (i_rk_addr > 4'd10) begin
      r_rk_data <= '0;
    end else begin
      r_rk_data <= r_rk[i_rk_addr];
    end
  end

  assign o_key_ready  = r_key_ready;
  assign o_busy       = r_busy;
  assign o_keys_valid = r_keys_valid;
  assign o_rk_data    = r_rk_data;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: FIPS-197 A.1 and all-zero key expansions, handshake, reset and read port.
// Latency: drives inputs and samples outputs on the falling edge, one read result per rising edge.
// Backpressure: holds or pulses key_valid against key_ready to exercise ignore and re-key paths.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rk_addr = '0;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [127:0] rk_data;

  key_sched_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_valid  (key_valid),
    .i_key_in     (key_in),
    .o_key_ready  (key_ready),
    .o_busy       (busy),
    .o_keys_valid (keys_valid),
    .i_rk_addr    (rk_addr),
    .o_rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [127:0] sb_q[$];
  logic [127:0] a1_rk [0:10];
  rd_vec_t      sweep_a1 [0:15];
  rd_vec_t      sweep_zero [0:15];

  localparam logic [127:0] A1_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] JUNK_KEY = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic bsy, input logic kv);
    chk_bit({tag, "_key_ready"}, key_ready, rdy);
    chk_bit({tag, "_busy"}, busy, bsy);
    chk_bit({tag, "_keys_valid"}, keys_valid, kv);
  endtask

  // Compare the oldest scoreboard entry against the current read data
  task automatic sb_check(input string tag);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, rk_data);
    end else begin
      chk(tag, rk_data, sb_q.pop_front());
    end
  endtask

  task automatic read_vec(input logic [3:0] a, input logic [127:0] e, input string tag);
    rk_addr = a;
    sb_q.push_back(e);
    tick();
    sb_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 16; i++) begin
      sweep_a1[i].addr   = 4'(i);
      sweep_a1[i].exp    = (i <= 10) ? a1_rk[i] : 128'h0;
      sweep_zero[i].addr = 4'(i);
      sweep_zero[i].exp  = 128'h0;
    end

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_status("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_rk_data", rk_data, 128'h0);
    rst_n = 1'b1;
    tick();

    // A.1 accept with read of index 3 held across its write edge; junk key offered in EXPAND cycle 4
    key_valid = 1'b1;
    key_in    = A1_KEY;
    rk_addr   = 4'd3;
    sb_q.push_back(128'h0);
    tick();
    key_valid = 1'b0;
    sb_check("e0_rd3");
    chk_status("e0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) begin
        key_valid = 1'b1;
        key_in    = JUNK_KEY;
        chk_bit("exp4_key_ready", key_ready, 1'b0);
      end else begin
        key_valid = 1'b0;
      end
      sb_q.push_back((k >= 4) ? a1_rk[3] : 128'h0);
      tick();
      sb_check($sformatf("coll_rd3_e%0d", k));
      chk_status($sformatf("a1_e%0d", k), (k == 10), (k < 10), (k == 10));
    end
    key_valid = 1'b0;

    // Read sweep in DONE, consecutive cycles
    for (int i = 0; i < 16; i++) read_vec(sweep_a1[i].addr, sweep_a1[i].exp, $sformatf("sweep_a1_%0d", i));

    // key_valid held high: re-accept only on the first edge that sees key_ready again
    key_valid = 1'b1;
    key_in    = A1_KEY;
    tick();
    chk_status("cont_c0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk_status($sformatf("cont_c%0d", k), (k == 10), (k < 10 || k == 11), (k == 10));
    end
    key_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_bit($sformatf("cont2_kv_e%0d", k), keys_valid, (k == 10));
    end
    read_vec(4'd10, a1_rk[10], "cont_rd10");

    // Re-key from DONE with all-zero key; the read on the accept edge returns the old set
    key_valid = 1'b1;
    key_in    = 128'h0;
    rk_addr   = 4'd10;
    sb_q.push_back(a1_rk[10]);
    tick();
    key_valid = 1'b0;
    sb_check("rekey_old_rd10");
    chk_status("rekey_e0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_bit($sformatf("zero_kv_e%0d", k), keys_valid, (k == 10));
    end
    read_vec(4'd1, Z_RK1, "zero_rd1");
    read_vec(4'd10, Z_RK10, "zero_rd10");
    read_vec(4'd0, 128'h0, "zero_rd0");

    // Reset asserted mid-expansion, checked before the next rising edge
    key_valid = 1'b1;
    key_in    = A1_KEY;
    rk_addr   = 4'd0;
    tick();
    key_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_rst_rd0", rk_data, A1_KEY);
    chk_bit("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("mid_rst", 1'b1, 1'b0, 1'b0);
    chk("mid_rst_rk_data", rk_data, 128'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) read_vec(sweep_zero[i].addr, sweep_zero[i].exp, $sformatf("post_rst_rd%0d", i));
    chk_status("post_rst", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
